// File: rtl/riscv_stat_defs_pkg.sv
// Shared encodings for the pipeline statistics producer: opcodes, branch
// funct3 codes, the ecall word and the stat class bit order.
package riscv_stat_defs;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  // Bit positions inside the 8-bit class vector.
  localparam int NUM_CLASS = 8;
  localparam int STAT_BEQ  = 7;
  localparam int STAT_BNE  = 6;
  localparam int STAT_BLT  = 5;
  localparam int STAT_BGE  = 4;
  localparam int STAT_BLTU = 3;
  localparam int STAT_BGEU = 2;
  localparam int STAT_JAL  = 1;
  localparam int STAT_JALR = 0;

endpackage

// File: rtl/stat_instr_classify.sv
// Purely combinational decode of an EX instruction word into a one-hot
// branch/jump class vector plus an ecall flag.
module stat_instr_classify
  import riscv_stat_defs::*;
#(
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0]      instr_i,
  output logic [NUM_CLASS-1:0] class_o,
  output logic                 is_ecall_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Opcode/funct3 decode; branch funct3 010/011 fall through to no class.
  always_comb begin
    class_o = '0;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  class_o[STAT_BEQ]  = 1'b1;
          F3_BNE:  class_o[STAT_BNE]  = 1'b1;
          F3_BLT:  class_o[STAT_BLT]  = 1'b1;
          F3_BGE:  class_o[STAT_BGE]  = 1'b1;
          F3_BLTU: class_o[STAT_BLTU] = 1'b1;
          F3_BGEU: class_o[STAT_BGEU] = 1'b1;
          default: class_o = '0;
        endcase
      end
      OP_JAL:  class_o[STAT_JAL] = 1'b1;
      OP_JALR: class_o[STAT_JALR] = (funct3 == F3_JALR);
      default: class_o = '0;
    endcase
  end

  // Only the exact ecall encoding counts; other SYSTEM instructions do not.
  assign is_ecall_o = (instr_i[31:0] == ECALL_WORD);

endmodule

// File: rtl/pl_stat_gen.sv
// Pipeline statistics producer: qualifies the instruction leaving EX with
// stall/flush controls and emits registered one-cycle stat pulses plus
// sticky halted / protocol-error flags.
module pl_stat_gen
  import riscv_stat_defs::*;
#(
  parameter bit HALT_ON_ECALL = 1'b1,
  parameter int ILEN          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [ILEN-1:0] ex_instr,
  input  logic            ex_flush,
  input  logic            stall_if,
  input  logic            stall_ex,
  output logic            stat_beq,
  output logic            stat_bne,
  output logic            stat_blt,
  output logic            stat_bge,
  output logic            stat_bltu,
  output logic            stat_bgeu,
  output logic            stat_jal,
  output logic            stat_jalr,
  output logic            stat_PL_flush,
  output logic            stat_PL_stall_if,
  output logic            stat_PL_stall_ex,
  output logic            stat_ecall,
  output logic            stat_retire,
  output logic            halted,
  output logic            stat_proto_err
);

  logic [NUM_CLASS-1:0] class_vec;
  logic                 is_ecall;
  logic                 adv;
  logic                 mute;

  logic [NUM_CLASS-1:0] class_q, class_d;
  logic                 flush_q, flush_d;
  logic                 stall_if_q, stall_if_d;
  logic                 stall_ex_q, stall_ex_d;
  logic                 ecall_q, ecall_d;
  logic                 retire_q, retire_d;
  logic                 halted_q, halted_d;
  logic                 proto_err_q, proto_err_d;

  stat_instr_classify #(.ILEN(ILEN)) u_classify (
    .instr_i    (ex_instr),
    .class_o    (class_vec),
    .is_ecall_o (is_ecall)
  );

  // Qualify events with advance and halt; accumulate sticky flags.
  always_comb begin
    adv  = ex_valid & ~stall_ex;
    // halted_q is the pre-edge value, so the ecall pulse itself still escapes.
    mute = HALT_ON_ECALL & halted_q;

    class_d    = (adv & ~mute) ? class_vec : '0;
    flush_d    = ex_flush & adv & ~mute;
    stall_if_d = stall_if & ~mute;
    stall_ex_d = stall_ex & ~mute;
    ecall_d    = is_ecall & adv & ~mute;
    retire_d   = adv & ~mute;
    halted_d   = halted_q | (HALT_ON_ECALL & is_ecall & adv);

    // Flush while stalled, flush on a bubble, or flush on a non-branch/jump.
    proto_err_d = proto_err_q
                | (ex_flush & (stall_ex | ~ex_valid))
                | (ex_flush & adv & ~(|class_vec));
  end

  // Output and sticky-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_q     <= '0;
      flush_q     <= 1'b0;
      stall_if_q  <= 1'b0;
      stall_ex_q  <= 1'b0;
      ecall_q     <= 1'b0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      class_q     <= class_d;
      flush_q     <= flush_d;
      stall_if_q  <= stall_if_d;
      stall_ex_q  <= stall_ex_d;
      ecall_q     <= ecall_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign stat_beq         = class_q[STAT_BEQ];
  assign stat_bne         = class_q[STAT_BNE];
  assign stat_blt         = class_q[STAT_BLT];
  assign stat_bge         = class_q[STAT_BGE];
  assign stat_bltu        = class_q[STAT_BLTU];
  assign stat_bgeu        = class_q[STAT_BGEU];
  assign stat_jal         = class_q[STAT_JAL];
  assign stat_jalr        = class_q[STAT_JALR];
  assign stat_PL_flush    = flush_q;
  assign stat_PL_stall_if = stall_if_q;
  assign stat_PL_stall_ex = stall_ex_q;
  assign stat_ecall       = ecall_q;
  assign stat_retire      = retire_q;
  assign halted           = halted_q;
  assign stat_proto_err   = proto_err_q;

endmodule

// File: tb/tb_pl_stat_gen.sv
// Bench for pl_stat_gen: two instances (HALT_ON_ECALL=1 and =0) share the
// stimulus; a reference model pushes expected output vectors to a queue
// that is popped and compared one cycle later.
module tb_pl_stat_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic        ex_flush;
  logic        stall_if;
  logic        stall_ex;

  // Output vector order:
  // beq bne blt bge bltu bgeu jal jalr flush sif sex ecall retire halted proto
  logic [14:0] obs [2];

  logic h_beq, h_bne, h_blt, h_bge, h_bltu, h_bgeu, h_jal, h_jalr;
  logic h_fl, h_sif, h_sex, h_ec, h_ret, h_halt, h_perr;
  logic k_beq, k_bne, k_blt, k_bge, k_bltu, k_bgeu, k_jal, k_jalr;
  logic k_fl, k_sif, k_sex, k_ec, k_ret, k_halt, k_perr;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [14:0] exp [2];
  } exp_t;

  exp_t sb_q[$];

  // Reference model state, index 0 = HALT_ON_ECALL=1, index 1 = 0.
  bit halt_cfg [2] = '{1'b1, 1'b0};
  bit m_halted [2];
  bit m_proto  [2];

  always #5 clk = ~clk;

  pl_stat_gen #(.HALT_ON_ECALL(1'b1), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_flush(ex_flush), .stall_if(stall_if), .stall_ex(stall_ex),
    .stat_beq(h_beq), .stat_bne(h_bne), .stat_blt(h_blt), .stat_bge(h_bge),
    .stat_bltu(h_bltu), .stat_bgeu(h_bgeu), .stat_jal(h_jal), .stat_jalr(h_jalr),
    .stat_PL_flush(h_fl), .stat_PL_stall_if(h_sif), .stat_PL_stall_ex(h_sex),
    .stat_ecall(h_ec), .stat_retire(h_ret), .halted(h_halt),
    .stat_proto_err(h_perr)
  );

  pl_stat_gen #(.HALT_ON_ECALL(1'b0), .ILEN(32)) dut_nohalt (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_flush(ex_flush), .stall_if(stall_if), .stall_ex(stall_ex),
    .stat_beq(k_beq), .stat_bne(k_bne), .stat_blt(k_blt), .stat_bge(k_bge),
    .stat_bltu(k_bltu), .stat_bgeu(k_bgeu), .stat_jal(k_jal), .stat_jalr(k_jalr),
    .stat_PL_flush(k_fl), .stat_PL_stall_if(k_sif), .stat_PL_stall_ex(k_sex),
    .stat_ecall(k_ec), .stat_retire(k_ret), .halted(k_halt),
    .stat_proto_err(k_perr)
  );

  assign obs[0] = {h_beq, h_bne, h_blt, h_bge, h_bltu, h_bgeu, h_jal, h_jalr,
                   h_fl, h_sif, h_sex, h_ec, h_ret, h_halt, h_perr};
  assign obs[1] = {k_beq, k_bne, k_blt, k_bge, k_bltu, k_bgeu, k_jal, k_jalr,
                   k_fl, k_sif, k_sex, k_ec, k_ret, k_halt, k_perr};

  // Independent decode: returns class bits {beq..jalr}.
  function automatic logic [7:0] ref_class(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    if (w[6:0] == 7'h63) begin
      if (w[14:12] == 3'd0) c = 8'b1000_0000;
      if (w[14:12] == 3'd1) c = 8'b0100_0000;
      if (w[14:12] == 3'd4) c = 8'b0010_0000;
      if (w[14:12] == 3'd5) c = 8'b0001_0000;
      if (w[14:12] == 3'd6) c = 8'b0000_1000;
      if (w[14:12] == 3'd7) c = 8'b0000_0100;
    end else if (w[6:0] == 7'h6F) begin
      c = 8'b0000_0010;
    end else if (w[6:0] == 7'h67 && w[14:12] == 3'd0) begin
      c = 8'b0000_0001;
    end
    return c;
  endfunction

  // Drive one cycle of inputs, predict, wait for the edge, pop and compare.
  task automatic step(input string name, input bit r, input bit v,
                      input logic [31:0] ins, input bit fl,
                      input bit sif, input bit sex);
    exp_t e;
    exp_t got;
    bit   go, mv;
    logic [7:0] c;
    rst = r; ex_valid = v; ex_instr = ins; ex_flush = fl;
    stall_if = sif; stall_ex = sex;
    e.name = name;
    c = ref_class(ins);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        m_halted[m] = 1'b0;
        m_proto[m]  = 1'b0;
        e.exp[m]    = '0;
      end else begin
        go = v && !sex;
        mv = halt_cfg[m] && m_halted[m];
        if (fl && (sex || !v)) m_proto[m] = 1'b1;
        if (fl && go && c == 8'h00) m_proto[m] = 1'b1;
        e.exp[m] = {(go && !mv) ? c : 8'h00,
                    fl && go && !mv,
                    sif && !mv,
                    sex && !mv,
                    go && !mv && ins == 32'h73,
                    go && !mv,
                    1'b0, 1'b0};
        if (halt_cfg[m] && go && ins == 32'h73) m_halted[m] = 1'b1;
        e.exp[m][1] = m_halted[m];
        e.exp[m][0] = m_proto[m];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      for (int m = 0; m < 2; m++) begin
        tests_run++;
        if (obs[m] !== got.exp[m]) begin
          tests_failed++;
          $display("FAIL %s[halt_cfg=%0d]: got %b expected %b",
                   got.name, halt_cfg[m], obs[m], got.exp[m]);
        end
      end
    end
  endtask

  task automatic idle(input string name);
    step(name, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle("reset_idle");
  endtask

  task automatic test_beq();
    step("beq", 1'b0, 1'b1, 32'h0020_8463, 1'b0, 1'b0, 1'b0);
    idle("beq_after");
  endtask

  task automatic test_stall_flush();
    for (int i = 0; i < 3; i++)
      step("bne_stalled", 1'b0, 1'b1, 32'h0020_9463, 1'b0, 1'b0, 1'b1);
    step("bne_flush", 1'b0, 1'b1, 32'h0020_9463, 1'b1, 1'b0, 1'b0);
    idle("bne_after");
  endtask

  task automatic test_ecall();
    step("ecall", 1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 1'b0);
    step("jal_halted", 1'b0, 1'b1, 32'h0000_006F, 1'b0, 1'b1, 1'b0);
    idle("halted_idle");
    step("ecall_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_proto_err();
    step("flush_stall", 1'b0, 1'b1, 32'h0020_8463, 1'b1, 1'b0, 1'b1);
    idle("proto_sticky");
    step("proto_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("flush_bubble", 1'b0, 1'b0, 32'h0020_8463, 1'b1, 1'b0, 1'b0);
    step("proto_rst2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("flush_nonbr", 1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    step("proto_rst3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_funct3();
    step("br_f3_010", 1'b0, 1'b1, 32'h0020_A063, 1'b0, 1'b0, 1'b0);
    step("bltu", 1'b0, 1'b1, 32'h0020_E063, 1'b0, 1'b0, 1'b0);
    step("blt", 1'b0, 1'b1, 32'h0020_C063, 1'b0, 1'b0, 1'b0);
    step("bge", 1'b0, 1'b1, 32'h0020_D063, 1'b0, 1'b0, 1'b0);
    step("bgeu", 1'b0, 1'b1, 32'h0020_F063, 1'b0, 1'b0, 1'b0);
    step("jalr_f3_1", 1'b0, 1'b1, 32'h0000_90E7, 1'b0, 1'b0, 1'b0);
    step("stall_if_only", 1'b0, 1'b0, 32'h0000_006F, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_rst_mid_stall();
    step("jalr_stalled", 1'b0, 1'b1, 32'h0000_80E7, 1'b0, 1'b0, 1'b1);
    step("jalr_rst", 1'b1, 1'b1, 32'h0000_80E7, 1'b0, 1'b0, 1'b1);
    idle("jalr_post_rst");
    step("jalr_again", 1'b0, 1'b1, 32'h0000_80E7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [8];
    tbl = '{32'h0020_8463, 32'h0020_9463, 32'h0020_C063, 32'h0020_E063,
            32'h0000_006F, 32'h0000_80E7, 32'h0020_A063, 32'h0000_0013};
    step("b2b_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step("b2b", 1'b0, ($urandom_range(0, 3) != 0),
           (i == 30) ? 32'h0000_0073 : tbl[$urandom_range(0, 7)],
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_instr = '0; ex_flush = 1'b0;
    stall_if = 1'b0; stall_ex = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_beq();
    test_stall_flush();
    test_ecall();
    test_proto_err();
    test_funct3();
    test_rst_mid_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
